pipe_stage_latch: RTL and testbench
===================================

// Module: pipe_stage_latch
// PURPOSE
//  Generic parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) for the 16-bit pipelined core.
//  Captures PC, instruction, NUM_DATA data words and a packed control vector every cycle.
//  Supports stall (hold all state) and flush (insert a bubble: NOP instruction, safe control, valid=0).
//  Provides a saturating consecutive-stall counter for hazard/perf debug.
// PARAMETERS
//  DATA_WIDTH  16       width of each data channel
//  NUM_DATA    7        number of data channels (e.g. A, B, SE5, ZE5, SE8, ZE8, SE11)
//  CTRL_WIDTH  16       width of packed control vector (RegWrite, MemWrite, MemToReg, ...)
//  CTRL_SAFE   0        control value loaded on reset/flush; must deassert all write enables
//  NOP_INSTR   16'h0800 instruction word loaded on reset/flush
//  CNT_WIDTH   4        width of stall counter
// PORTS
//  clk        in   1                      clock, all state updates on rising edge
//  rst        in   1                      synchronous, active-high reset
//  stall      in   1                      hold all registered state this cycle
//  flush      in   1                      replace stage contents with a bubble
//  valid_in   in   1                      upstream stage holds a real instruction
//  pc_in      in   16                     PC+2 / PC of the instruction
//  instr_in   in   16                     instruction word
//  data_in    in   NUM_DATA*DATA_WIDTH    packed data channels, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//  ctrl_in    in   CTRL_WIDTH             packed control vector
//  valid_out  out  1                      registered valid
//  pc_out     out  16                     registered PC
//  instr_out  out  16                     registered instruction
//  data_out   out  NUM_DATA*DATA_WIDTH    registered data, same packing as data_in
//  ctrl_out   out  CTRL_WIDTH             registered control
//  stall_cnt  out  CNT_WIDTH              consecutive cycles held by stall while valid_out=1
// BEHAVIOUR
//  - Single clock domain; reset synchronous active-high. All outputs registered, 1-cycle latency in->out.
//  - Per-edge priority: rst > flush > stall > load.
//  - rst: valid_out=0, pc_out=0, instr_out=NOP_INSTR, data_out=0, ctrl_out=CTRL_SAFE, stall_cnt=0.
//  - flush (rst=0): same values as reset, except pc_out=pc_in (keeps PC visible for debug). Flush beats stall.
//  - stall (rst=0, flush=0): every output holds its value, including valid_out. stall_cnt increments
//    if valid_out=1, saturating at 2^CNT_WIDTH-1 (no wrap); stays 0 while valid_out=0.
//  - load (none asserted): all outputs take their *_in values; valid_out=valid_in; stall_cnt=0.
//  - valid_in=0 on load: data/pc/instr/ctrl still captured unmodified; downstream gates on valid_out.
//    ctrl_in is NOT masked here — upstream must drive CTRL_SAFE when valid_in=0.
//  - Channels are independent; no arithmetic on data. NUM_DATA>=1, DATA_WIDTH>=1, CNT_WIDTH>=1.
//  - Reset mid-stall or mid-flush sequence: reset wins and clears stall_cnt the same edge.
//  - Inputs changing while stall=1 are ignored; no combinational path from any input to any output.
// TESTING
//  1 Reset: rst=1 one edge with random inputs -> valid_out=0, instr_out=16'h0800, data_out=0, ctrl_out=0, stall_cnt=0.
//  2 Load: valid_in=1, pc_in=16'h0042, instr_in=16'hC123, ch0=16'hAAAA, ch6=16'h5555, ctrl_in=16'h00F1 ->
//    next edge outputs equal those values, valid_out=1.
//  3 Stall: after case 2, stall=1 for 20 edges with inputs changed to 16'hFFFF -> outputs unchanged,
//    stall_cnt reads 1,2,..,15 then stays 15 (CNT_WIDTH=4); stall=0 next edge -> new values, stall_cnt=0.
//  4 Flush vs stall: stall=1, flush=1, pc_in=16'h0100 -> valid_out=0, instr_out=16'h0800,
//    ctrl_out=0, data_out=0, pc_out=16'h0100, stall_cnt=0.
//  5 Bubble stall: valid_out=0, stall=1 for 5 edges -> stall_cnt stays 0, outputs held.
//  6 Reset mid-stall: stall_cnt=7, assert rst with stall=1 -> next edge all reset values, stall_cnt=0.
//  Run cases 2-4 also with NUM_DATA=2, DATA_WIDTH=32, CTRL_WIDTH=5 to check packing.

Source files
------------

// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: parametrised inter-stage pipeline register with stall, flush and a saturating stall counter
module pipe_stage_latch #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DATA = 7,
    parameter int CTRL_WIDTH = 16,
    parameter logic [CTRL_WIDTH-1:0] CTRL_SAFE = '0,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter int CNT_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           flush,
    input  logic                           valid_in,
    input  logic [15:0]                    pc_in,
    input  logic [15:0]                    instr_in,
    input  logic [NUM_DATA*DATA_WIDTH-1:0] data_in,
    input  logic [CTRL_WIDTH-1:0]          ctrl_in,
    output logic                           valid_out,
    output logic [15:0]                    pc_out,
    output logic [15:0]                    instr_out,
    output logic [NUM_DATA*DATA_WIDTH-1:0] data_out,
    output logic [CTRL_WIDTH-1:0]          ctrl_out,
    output logic [CNT_WIDTH-1:0]           stall_cnt
);
    // rst > flush > stall > load; a flush keeps the incoming PC visible for debug
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_out <= 1'b0;
            pc_out    <= rst ? 16'h0000 : pc_in;
            instr_out <= NOP_INSTR;
            data_out  <= '0;
            ctrl_out  <= CTRL_SAFE;
            stall_cnt <= '0;
        end else if (stall) begin
            if (valid_out && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end else begin
            valid_out <= valid_in;
            pc_out    <= pc_in;
            instr_out <= instr_in;
            data_out  <= data_in;
            ctrl_out  <= ctrl_in;
            stall_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb_pipe_stage_latch: random and directed checks of two pipe_stage_latch configurations against a reference model
module tb_pipe_stage_latch;
    logic clk = 0;
    logic rst, stall, flush, valid_in;
    logic [15:0] pc_in, instr_in;
    logic [111:0] din;
    logic [15:0] cin;

    logic va, vb;
    logic [15:0] pca, pcb, ia, ib;
    logic [111:0] da;
    logic [63:0] db;
    logic [15:0] ca;
    logic [4:0] cb;
    logic [3:0] na, nb;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic v;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [111:0] data;
        logic [15:0] ctrl;
        int cnt;
    } st_t;

    st_t ma, mb;

    always #5 clk = ~clk;

    pipe_stage_latch dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .instr_in(instr_in), .data_in(din), .ctrl_in(cin),
        .valid_out(va), .pc_out(pca), .instr_out(ia), .data_out(da), .ctrl_out(ca), .stall_cnt(na)
    );

    pipe_stage_latch #(.DATA_WIDTH(32), .NUM_DATA(2), .CTRL_WIDTH(5)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .instr_in(instr_in), .data_in(din[63:0]), .ctrl_in(cin[4:0]),
        .valid_out(vb), .pc_out(pcb), .instr_out(ib), .data_out(db), .ctrl_out(cb), .stall_cnt(nb)
    );

    function automatic st_t nxt(st_t s, logic [111:0] dmask, logic [15:0] cmask);
        st_t n = s;
        if (rst || flush) begin
            n.v = 0;
            n.pc = rst ? 16'h0 : pc_in;
            n.instr = 16'h0800;
            n.data = '0;
            n.ctrl = '0;
            n.cnt = 0;
        end else if (stall) begin
            n.cnt = s.v ? ((s.cnt + 1 > 15) ? 15 : s.cnt + 1) : s.cnt;
        end else begin
            n.v = valid_in;
            n.pc = pc_in;
            n.instr = instr_in;
            n.data = din & dmask;
            n.ctrl = cin & cmask;
            n.cnt = 0;
        end
        return n;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        ma = nxt(ma, {112{1'b1}}, 16'hFFFF);
        mb = nxt(mb, {48'h0, {64{1'b1}}}, 16'h001F);
        #1;
        chk("a_valid", 128'(va), 128'(ma.v));
        chk("a_pc", 128'(pca), 128'(ma.pc));
        chk("a_instr", 128'(ia), 128'(ma.instr));
        chk("a_data", 128'(da), 128'(ma.data));
        chk("a_ctrl", 128'(ca), 128'(ma.ctrl));
        chk("a_cnt", 128'(na), 128'(ma.cnt));
        chk("b_valid", 128'(vb), 128'(mb.v));
        chk("b_pc", 128'(pcb), 128'(mb.pc));
        chk("b_instr", 128'(ib), 128'(mb.instr));
        chk("b_data", 128'(db), 128'(mb.data));
        chk("b_ctrl", 128'(cb), 128'(mb.ctrl));
        chk("b_cnt", 128'(nb), 128'(mb.cnt));
    endtask

    task automatic rnd_in();
        valid_in = 1'($urandom);
        pc_in = 16'($urandom);
        instr_in = 16'($urandom);
        din = {$urandom, $urandom, $urandom, $urandom};
        cin = 16'($urandom);
    endtask

    task automatic load_case2();
        rst = 0; flush = 0; stall = 0; valid_in = 1;
        pc_in = 16'h0042; instr_in = 16'hC123; cin = 16'h00F1;
        din = '0; din[15:0] = 16'hAAAA; din[111:96] = 16'h5555;
        step();
    endtask

    initial begin
        rst = 1; flush = 0; stall = 0;
        rnd_in();
        step();
        chk("rst_valid", 128'(va), 128'(0));
        chk("rst_instr", 128'(ia), 128'(16'h0800));
        chk("rst_data", 128'(da), 128'(0));
        chk("rst_cnt", 128'(nb), 128'(0));

        load_case2();
        chk("ld_pc", 128'(pca), 128'(16'h0042));
        chk("ld_ch6", 128'(da[111:96]), 128'(16'h5555));
        chk("ld_b_data", 128'(db), 128'(64'h0000_0000_0000_AAAA));
        chk("ld_b_ctrl", 128'(cb), 128'(5'h11));

        stall = 1;
        pc_in = 16'hFFFF; instr_in = 16'hFFFF; din = {112{1'b1}}; cin = 16'hFFFF;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("stall_cnt_lit", 128'(na), 128'(k < 15 ? k : 15));
            chk("stall_hold", 128'(ia), 128'(16'hC123));
        end
        stall = 0;
        step();
        chk("unstall_instr", 128'(ia), 128'(16'hFFFF));
        chk("unstall_cnt", 128'(na), 128'(0));

        stall = 1; flush = 1; pc_in = 16'h0100;
        step();
        chk("flush_pc", 128'(pcb), 128'(16'h0100));
        chk("flush_valid", 128'(va), 128'(0));
        chk("flush_ctrl", 128'(ca), 128'(0));

        flush = 0; stall = 1;
        for (int k = 0; k < 5; k++) begin
            rnd_in();
            step();
            chk("bubble_cnt", 128'(na), 128'(0));
        end

        load_case2();
        stall = 1;
        for (int k = 0; k < 7; k++) step();
        chk("pre_rst_cnt", 128'(na), 128'(7));
        rst = 1;
        step();
        chk("rst_stall_cnt", 128'(na), 128'(0));
        chk("rst_stall_pc", 128'(pca), 128'(0));

        for (int k = 0; k < 400; k++) begin
            rnd_in();
            rst = ($urandom_range(0, 29) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
